dmi_jtag_dtm: RTL
=================

DMI_JTAG_DTM -- requirements
Module: dmi_jtag_dtm

Purpose: JTAG Debug Transport Module (RISC-V Debug v0.13.2). Oversamples an external JTAG port on the system clock and drives the DMI request/response port of the downstream Debug Module.

Interface
- Parameters (name, default, meaning):
  - REQ-001 IDCODE, 32'h1000_0001, value captured by the IDCODE instruction; bit 0 SHALL be 1.
  - REQ-002 ABITS, 7, DMI address width; fixed at 7.
- Ports (name, direction, width, meaning):
  - REQ-003 clk, input, 1, single system clock for all logic.
  - REQ-004 reset_n, input, 1, asynchronous active-low reset.
  - REQ-005 tck, input, 1, JTAG test clock; asynchronous to clk; oversampled.
  - REQ-006 tms, input, 1, JTAG mode select; oversampled.
  - REQ-007 tdi, input, 1, JTAG serial data in; oversampled.
  - REQ-008 tdo, output, 1, JTAG serial data out.
  - REQ-009 tdo_en, output, 1, tdo valid; high only in Shift-IR and Shift-DR.
  - REQ-010 dmi_wr, output, 1, one-clk DMI write strobe.
  - REQ-011 dmi_rd, output, 1, one-clk DMI read strobe.
  - REQ-012 dmi_addr, output, 7, DMI register address.
  - REQ-013 dmi_wdata, output, 32, DMI write data.
  - REQ-014 dmi_rdata, input, 32, DMI read data; combinationally valid while dmi_rd is high.

Function
- REQ-015 tck, tms and tdi SHALL each pass through a 2-flop synchronizer on clk.
  - tck_rise = synced tck 1 and previous 0; tck_fall = synced tck 0 and previous 1.
  - tck SHALL stay high and low for at least 3 clk each; faster tck is unsupported.
- REQ-016 The 16-state IEEE 1149.1 TAP FSM SHALL advance only on tck_rise, using synced tms.
  - Five consecutive tck_rise with tms=1 SHALL reach Test-Logic-Reset from any state.
- REQ-017 In Test-Logic-Reset, IR SHALL be 5'h01 (IDCODE).
- REQ-018 IR is 5 bits.
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts: tdi into MSB, LSB toward tdo.
  - Update-IR copies the shift register into IR.
- REQ-019 Instruction decode:
  - 5'h01: IDCODE (32-bit).
  - 5'h10: dtmcs (32-bit).
  - 5'h11: dmi (41-bit).
  - All other values: BYPASS (1-bit, captures 0).
- REQ-020 Capture and shift actions SHALL occur on tck_rise while in the Capture or Shift state.
  - Update actions SHALL occur on tck_fall while in Update-IR or Update-DR.
- REQ-021 Shifting: every DR shifts tdi into its MSB and the LSB toward tdo.
  - tdo SHALL be loaded from the active shift register LSB on tck_fall in Shift-IR/Shift-DR.
  - tdo SHALL be 0 when tdo_en is 0.
- REQ-022 dtmcs capture value:
  - [31:18] = 0; [17:16] = 0; [15] = 0.
  - [14:12] idle = 3'd1.
  - [11:10] = dmistat.
  - [9:4] abits = 6'd7.
  - [3:0] version = 4'd1.
- REQ-023 dtmcs update: if shifted bit 16 (dmireset) or bit 17 (dmihardreset) is 1, dmistat SHALL clear to 0; all other bits are ignored.
- REQ-024 dmi capture value: {last_addr[6:0], last_data[31:0], dmistat[1:0]}.
  - last_data holds the most recent read response or written data.
- REQ-025 dmi update, decoded from shifted value {addr[40:34], data[33:2], op[1:0]}, applies only when dmistat == 0:
  - op 0: no action.
  - op 1: assert dmi_rd for exactly one clk with dmi_addr = addr; latch dmi_rdata into last_data at that same clk edge.
  - op 2: assert dmi_wr for exactly one clk with dmi_addr = addr and dmi_wdata = data.
  - op 3: set dmistat to 2'd2 (failed); no strobe.
- REQ-026 Strobe timing: dmi_rd/dmi_wr SHALL assert in the clk cycle immediately after the tck_fall detection in Update-DR.
  - dmi_rd and dmi_wr SHALL never be high together.
- REQ-027 While dmistat != 0, dmi updates SHALL be ignored with no strobe; capture still reports dmistat.
- REQ-028 dmi_addr and dmi_wdata SHALL hold their last values between strobes.

Reset
- REQ-029 When reset_n = 0, asynchronously:
  - TAP state = Test-Logic-Reset, IR = 5'h01.
  - dmistat = 0; synchronizers = 0.
  - tdo = 0, tdo_en = 0, dmi_wr = 0, dmi_rd = 0.
  - dmi_addr = 0, dmi_wdata = 0, last_addr = 0, last_data = 0.
- REQ-030 Reset asserted mid-scan SHALL abort it with no DMI strobe; the first tck_rise after release is treated as a fresh edge.

Verification
- REQ-031 Reset, then Capture/Shift 32 bits of DR with IR = IDCODE: tdo yields 32'h1000_0001, LSB first.
- REQ-032 IR = 5'h10, scan dtmcs: 32'h0000_1071 captured.
- REQ-033 IR = 5'h11, scan {7'h10, 32'h8000_0001, 2'd2}: one-clk dmi_wr with dmi_addr = 7'h10, dmi_wdata = 32'h8000_0001, dmi_rd = 0.
- REQ-034 Scan a read of 7'h11 with dmi_rdata = 32'h0000_0C82, then a nop scan: the second capture shifts out {7'h11, 32'h0000_0C82, 2'd0}.
- REQ-035 Scan op = 3: no strobe; dtmcs reads dmistat = 2; a following write is ignored; a dtmcs write with bit 16 = 1 clears dmistat; the next write strobes.
- REQ-036 tms = 1 for 5 tck from Shift-DR: Test-Logic-Reset, IR = 5'h01, no DMI strobe.

Source files
------------

// File: rtl/dmi_jtag_dtm.sv
// JTAG Debug Transport Module: oversamples a JTAG port on clk, runs the
// IEEE 1149.1 TAP, and turns dmi scans into one-clk DMI read/write strobes.
module dmi_jtag_dtm #(
  parameter logic [31:0] IDCODE = 32'h1000_0001,
  parameter int          ABITS  = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tck,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  output logic             dmi_wr,
  output logic             dmi_rd,
  output logic [ABITS-1:0] dmi_addr,
  output logic [31:0]      dmi_wdata,
  input  logic [31:0]      dmi_rdata
);
  localparam int DRW = ABITS + 34;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  logic tck_s1_q, tck_s2_q, tck_prev_q;
  logic tms_s1_q, tms_q, tdi_s1_q, tdi_q;
  logic tck_rise, tck_fall;
  tap_e state_q, state_d;

  logic [4:0]       ir_q, ir_sr_q;
  logic [DRW-1:0]   dr_sr_q, dr_cap, dr_shift;
  logic             tdo_q;
  logic [1:0]       dmistat_q;
  logic [ABITS-1:0] last_addr_q, dmi_addr_q;
  logic [31:0]      last_data_q, dmi_wdata_q;
  logic             dmi_rd_q, dmi_wr_q;

  // Two-flop synchronizers plus a history flop for tck edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tck_s1_q <= 1'b0; tck_s2_q <= 1'b0; tck_prev_q <= 1'b0;
      tms_s1_q <= 1'b0; tms_q    <= 1'b0;
      tdi_s1_q <= 1'b0; tdi_q    <= 1'b0;
    end else begin
      tck_s1_q <= tck;  tck_s2_q <= tck_s1_q; tck_prev_q <= tck_s2_q;
      tms_s1_q <= tms;  tms_q    <= tms_s1_q;
      tdi_s1_q <= tdi;  tdi_q    <= tdi_s1_q;
    end
  end

  assign tck_rise = tck_s2_q & ~tck_prev_q;
  assign tck_fall = ~tck_s2_q & tck_prev_q;

  // TAP state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= TLR;
    else          state_q <= state_d;
  end

  // TAP next state, advanced only on a tck rising edge
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TLR:    state_d = tms_q ? TLR    : RTI;
        RTI:    state_d = tms_q ? SEL_DR : RTI;
        SEL_DR: state_d = tms_q ? SEL_IR : CAP_DR;
        CAP_DR: state_d = tms_q ? EX1_DR : SH_DR;
        SH_DR:  state_d = tms_q ? EX1_DR : SH_DR;
        EX1_DR: state_d = tms_q ? UPD_DR : PAU_DR;
        PAU_DR: state_d = tms_q ? EX2_DR : PAU_DR;
        EX2_DR: state_d = tms_q ? UPD_DR : SH_DR;
        UPD_DR: state_d = tms_q ? SEL_DR : RTI;
        SEL_IR: state_d = tms_q ? TLR    : CAP_IR;
        CAP_IR: state_d = tms_q ? EX1_IR : SH_IR;
        SH_IR:  state_d = tms_q ? EX1_IR : SH_IR;
        EX1_IR: state_d = tms_q ? UPD_IR : PAU_IR;
        PAU_IR: state_d = tms_q ? EX2_IR : PAU_IR;
        EX2_IR: state_d = tms_q ? UPD_IR : SH_IR;
        UPD_IR: state_d = tms_q ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // Capture value and one-step shift of the DR selected by IR;
  // every register shifts tdi into its own MSB
  always_comb begin
    dr_cap   = '0;
    dr_shift = '0;
    unique case (ir_q)
      5'h01: begin
        dr_cap[31:0]   = IDCODE;
        dr_shift[31:0] = {tdi_q, dr_sr_q[31:1]};
      end
      5'h10: begin
        dr_cap[31:0]   = {17'd0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};
        dr_shift[31:0] = {tdi_q, dr_sr_q[31:1]};
      end
      5'h11: begin
        dr_cap   = {last_addr_q, last_data_q, dmistat_q};
        dr_shift = {tdi_q, dr_sr_q[DRW-1:1]};
      end
      default: dr_shift[0] = tdi_q;  // BYPASS captures 0
    endcase
  end

  // Datapath: capture/shift on tck rise, tdo/update on tck fall, DMI strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q        <= 5'h01;
      ir_sr_q     <= '0;
      dr_sr_q     <= '0;
      tdo_q       <= 1'b0;
      dmistat_q   <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      dmi_addr_q  <= '0;
      dmi_wdata_q <= '0;
      dmi_rd_q    <= 1'b0;
      dmi_wr_q    <= 1'b0;
    end else begin
      dmi_rd_q <= 1'b0;
      dmi_wr_q <= 1'b0;
      // read data is valid while the strobe is high
      if (dmi_rd_q) last_data_q <= dmi_rdata;
      if (tck_rise) begin
        unique case (state_q)
          CAP_IR:  ir_sr_q <= 5'b00001;
          SH_IR:   ir_sr_q <= {tdi_q, ir_sr_q[4:1]};
          CAP_DR:  dr_sr_q <= dr_cap;
          SH_DR:   dr_sr_q <= dr_shift;
          default: ;
        endcase
      end
      if (tck_fall) begin
        unique case (state_q)
          SH_IR:  tdo_q <= ir_sr_q[0];
          SH_DR:  tdo_q <= dr_sr_q[0];
          UPD_IR: ir_q  <= ir_sr_q;
          UPD_DR: begin
            if (ir_q == 5'h10) begin
              if (dr_sr_q[16] | dr_sr_q[17]) dmistat_q <= '0;
            end else if (ir_q == 5'h11 && dmistat_q == 2'd0) begin
              unique case (dr_sr_q[1:0])
                2'd1: begin
                  dmi_rd_q    <= 1'b1;
                  dmi_addr_q  <= dr_sr_q[DRW-1 -: ABITS];
                  last_addr_q <= dr_sr_q[DRW-1 -: ABITS];
                end
                2'd2: begin
                  dmi_wr_q    <= 1'b1;
                  dmi_addr_q  <= dr_sr_q[DRW-1 -: ABITS];
                  dmi_wdata_q <= dr_sr_q[33:2];
                  last_addr_q <= dr_sr_q[DRW-1 -: ABITS];
                  last_data_q <= dr_sr_q[33:2];
                end
                2'd3:    dmistat_q <= 2'd2;
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
      if (state_q == TLR) ir_q <= 5'h01;
    end
  end

  assign tdo_en    = (state_q == SH_IR) || (state_q == SH_DR);
  assign tdo       = tdo_en & tdo_q;
  assign dmi_rd    = dmi_rd_q;
  assign dmi_wr    = dmi_wr_q;
  assign dmi_addr  = dmi_addr_q;
  assign dmi_wdata = dmi_wdata_q;

endmodule
